bus_host_arbiter: RTL

Round-robin arbiter that shares one device-side request/grant/rvalid port between NrHosts bus hosts, e.g. core data port, DMA engine and debug module in the simple system. It sits in front of the address-decoding bus and owns all sequencing for multi-host access: host selection, grant generation and in-order return routing of responses to the issuing host. Multiple transactions may be outstanding; responses always return in issue order.

---
 rtl/bus_arb_pkg.sv | 35 +++
 rtl/bus_arb_id_fifo.sv | 60 ++++++
 rtl/bus_host_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the multi-host bus arbiter.
package bus_arb_pkg;

  localparam int unsigned MaxHosts  = 8;
  localparam int unsigned PickWidth = 3;

  typedef struct packed {
    logic                 found;
    logic [PickWidth-1:0] idx;
  } pick_t;

  // Host index width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // First requester at or after ptr, wrapping modulo n (n <= MaxHosts).
  function automatic pick_t rr_pick(input logic [MaxHosts-1:0] req,
                                    input int unsigned         ptr,
                                    input int unsigned         n);
    pick_t       res;
    int unsigned cand;
    res = '0;
    for (int unsigned i = 0; i < MaxHosts; i++) begin
      cand = ptr + i;
      if (cand >= n) cand = cand - n;
      if (i < n && !res.found && req[cand[PickWidth-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[PickWidth-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bus_arb_id_fifo.sv
// In-order FIFO of granted host IDs awaiting their device response.
module bus_arb_id_fifo #(
  parameter int Depth    = 2,
  parameter int Width    = 1,
  parameter int CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [Width-1:0]    push_data_i,
  input  logic                pop_i,
  output logic [Width-1:0]    head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] count_o
);

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]    mem [Depth];
  logic [PtrWidth-1:0] wr_ptr;
  logic [PtrWidth-1:0] rd_ptr;
  logic [CntWidth-1:0] count;
  logic                do_push;
  logic                do_pop;

  function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count == CntWidth'(Depth));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign head_o  = mem[rd_ptr];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one device port between several bus hosts,
// with in-order routing of responses back to the issuing host.
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NrHosts        = 3,
  parameter int MaxOutstanding = 2,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrHosts-1:0]             host_req_i,
  output logic [NrHosts-1:0]             host_gnt_o,
  input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
  input  logic [NrHosts-1:0]             host_we_i,
  input  logic [NrHosts*DataWidth/8-1:0] host_be_i,
  input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
  output logic [NrHosts-1:0]             host_rvalid_o,
  output logic [DataWidth-1:0]           host_rdata_o,
  output logic                           host_err_o,
  output logic                           dev_req_o,
  input  logic                           dev_gnt_i,
  output logic [AddrWidth-1:0]           dev_addr_o,
  output logic                           dev_we_o,
  output logic [DataWidth/8-1:0]         dev_be_o,
  output logic [DataWidth-1:0]           dev_wdata_o,
  input  logic                           dev_rvalid_i,
  input  logic [DataWidth-1:0]           dev_rdata_i,
  input  logic                           dev_err_i,
  output logic                           unexpected_rsp_o
);

  localparam int IdWidth  = int'(id_width(NrHosts));
  localparam int BeWidth  = DataWidth / 8;
  localparam int CntWidth = $clog2(MaxOutstanding + 1);

  logic [IdWidth-1:0]  rr_ptr;
  logic                lock;
  logic [IdWidth-1:0]  locked_id;
  logic [MaxHosts-1:0] req_ext;
  pick_t               pick;
  logic [IdWidth-1:0]  winner;
  logic                grant;
  logic                fifo_full;
  logic                fifo_empty;
  logic [IdWidth-1:0]  fifo_head;
  logic [CntWidth-1:0] fifo_count;
  logic                rsp_pop;

  assign req_ext = MaxHosts'(host_req_i);
  assign pick    = rr_pick(req_ext, 32'(rr_ptr), NrHosts);
  // A stalled request keeps its host so the device sees stable fields.
  assign winner  = lock ? locked_id : pick.idx[IdWidth-1:0];

  // A full ID FIFO blocks new requests even if a response pops this cycle.
  assign dev_req_o = (|host_req_i) && !fifo_full;
  assign grant     = dev_req_o && dev_gnt_i;

  assign dev_addr_o  = host_addr_i[winner*AddrWidth +: AddrWidth];
  assign dev_we_o    = host_we_i[winner];
  assign dev_be_o    = host_be_i[winner*BeWidth +: BeWidth];
  assign dev_wdata_o = host_wdata_i[winner*DataWidth +: DataWidth];

  assign rsp_pop          = dev_rvalid_i && !fifo_empty;
  assign unexpected_rsp_o = dev_rvalid_i && fifo_empty;
  assign host_rdata_o     = dev_rdata_i;
  assign host_err_o       = dev_err_i;

  // Grant goes to the selected host in the same cycle the device accepts.
  always_comb begin
    host_gnt_o = '0;
    if (grant) host_gnt_o[winner] = 1'b1;
  end

  // Response is routed to the oldest outstanding host with zero latency.
  always_comb begin
    host_rvalid_o = '0;
    if (rsp_pop) host_rvalid_o[fifo_head] = 1'b1;
  end

  // Round-robin pointer advance and stall lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr    <= '0;
      lock      <= 1'b0;
      locked_id <= '0;
    end else if (grant) begin
      rr_ptr <= (winner == IdWidth'(NrHosts - 1)) ? '0 : winner + 1'b1;
      lock   <= 1'b0;
    end else if (dev_req_o) begin
      lock      <= 1'b1;
      locked_id <= winner;
    end
  end

  bus_arb_id_fifo #(
    .Depth    (MaxOutstanding),
    .Width    (IdWidth),
    .CntWidth (CntWidth)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (grant),
    .push_data_i (winner),
    .pop_i       (rsp_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(host_gnt_o));
  a_rvalid_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(host_rvalid_o));
  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    32'(fifo_count) <= MaxOutstanding);

  for (genvar h = 0; h < NrHosts; h++) begin : g_proto
    a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
      host_req_i[h] && !host_gnt_o[h] |=> host_req_i[h] &&
      $stable(host_addr_i[h*AddrWidth +: AddrWidth]));
  end

endmodule
